// File: rtl/rca_dispatch_scheduler_pkg.sv
// taiga_types: shared RCA scheduler types (slot state, default sizes, writeback record)
package taiga_types;
  localparam int NUM_RCAS = 3;
  localparam int ID_W = 3;
  localparam int XLEN = 32;
  localparam int NUM_WRITE_PORTS = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} rca_slot_state_t;
  typedef struct packed {
    logic done;
    logic [ID_W-1:0] id;
    logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd;
    logic err;
  } rca_wb_t;
endpackage

// File: rtl/rca_dispatch_scheduler_rr_arbiter.sv
// rca_rr_arbiter: round-robin arbiter with one-hot grant; pointer moves past the winner on load
// ports: req (requesters), load (grant consumed this cycle), gnt (one-hot grant)
module rca_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         load,
  output logic [N-1:0] gnt
);
  logic [IW-1:0] ptr_q, ptr_d, win;
  int idx;
  always_comb begin
    gnt = '0;
    win = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        win = IW'(idx);
      end
    end
    ptr_d = load ? (win == IW'(N - 1) ? '0 : win + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/rca_dispatch_scheduler.sv
// rca_dispatch_scheduler: gates config writes against running RCAs, starts RCAs, arbitrates results to writeback
// ports: req_* issue handshake; cfg_* config strobe; rca_start/done/result/busy per RCA; wb_* writeback held until wb_ack
// option: RCA_SCHED_TIMEOUT_EN adds a per-slot watchdog forcing an error completion after TIMEOUT_CYCLES in RUN
module rca_dispatch_scheduler #(
  parameter int NUM_RCAS = taiga_types::NUM_RCAS,
  parameter int ID_W = 3,
  parameter int XLEN = 32,
  parameter int NUM_WRITE_PORTS = 5,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SEL_W = $clog2(NUM_RCAS + 1)
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            req_valid,
  output logic                                            req_ready,
  input  logic [ID_W-1:0]                                 req_id,
  input  logic [SEL_W-1:0]                                req_rca_sel,
  input  logic                                            req_is_config,
  output logic                                            cfg_wr_en,
  output logic [SEL_W-1:0]                                cfg_rca_sel,
  output logic [NUM_RCAS-1:0]                             rca_start,
  input  logic [NUM_RCAS-1:0]                             rca_done,
  input  logic [NUM_RCAS-1:0][NUM_WRITE_PORTS-1:0][XLEN-1:0] rca_result,
  output logic [NUM_RCAS-1:0]                             rca_busy,
  output logic                                            wb_done,
  output logic [ID_W-1:0]                                 wb_id,
  output logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]            wb_rd,
  output logic                                            wb_err,
  input  logic                                            wb_ack
);
  import taiga_types::*;
  typedef logic [NUM_WRITE_PORTS-1:0][XLEN-1:0] rd_t;
  rca_slot_state_t state_q [NUM_RCAS], state_d [NUM_RCAS];
  logic [ID_W-1:0] id_q [NUM_RCAS], id_d [NUM_RCAS];
  rd_t res_q [NUM_RCAS], res_d [NUM_RCAS];
  logic [NUM_RCAS-1:0] err_q, err_d, start_q, start_d;
  logic cfg_wr_q, cfg_wr_d, cfg_pending_q, cfg_pending_d;
  logic [SEL_W-1:0] cfg_sel_q, cfg_sel_d;
  logic [ID_W-1:0] cfg_id_q, cfg_id_d, wb_id_q, wb_id_d;
  logic wb_done_q, wb_done_d, wb_err_q, wb_err_d;
  rd_t wb_rd_q, wb_rd_d;
  logic [NUM_RCAS:0] arb_req, arb_gnt;
  logic sel_ok, slot_idle, accept, exec_acc, pend_acc, wb_load;
`ifdef RCA_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q [NUM_RCAS], cnt_d [NUM_RCAS];
  always_comb
    for (int i = 0; i < NUM_RCAS; i++) cnt_d[i] = state_q[i] == RUN ? cnt_q[i] + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    for (int i = 0; i < NUM_RCAS; i++) cnt_q[i] <= !rst_n ? '0 : cnt_d[i];
`endif
  always_comb begin
    slot_idle = 1'b0;
    for (int i = 0; i < NUM_RCAS; i++) begin
      rca_busy[i] = state_q[i] != IDLE;
      arb_req[i] = state_q[i] == DONE;
      if (req_rca_sel == SEL_W'(i)) slot_idle = state_q[i] == IDLE;
    end
    arb_req[NUM_RCAS] = cfg_pending_q;
    sel_ok = req_rca_sel < SEL_W'(NUM_RCAS);
    // out-of-range selects take the config-pending path and complete as a zero writeback
    req_ready = sel_ok ? slot_idle && !(req_is_config && cfg_pending_q) : !cfg_pending_q;
    accept = req_valid && req_ready;
    exec_acc = accept && sel_ok && !req_is_config;
    pend_acc = accept && (req_is_config || !sel_ok);
    wb_load = |arb_req && (!wb_done_q || wb_ack);
  end
  rca_rr_arbiter #(.N(NUM_RCAS + 1)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(arb_req), .load(wb_load), .gnt(arb_gnt)
  );
  always_comb begin
    state_d = state_q;
    id_d = id_q;
    res_d = res_q;
    err_d = err_q;
    start_d = '0;
    cfg_wr_d = 1'b0;
    cfg_sel_d = '0;
    cfg_pending_d = cfg_pending_q;
    cfg_id_d = cfg_id_q;
    wb_done_d = wb_done_q;
    wb_id_d = wb_id_q;
    wb_rd_d = wb_rd_q;
    wb_err_d = wb_err_q;
    for (int i = 0; i < NUM_RCAS; i++)
      case (state_q[i])
        IDLE: if (exec_acc && req_rca_sel == SEL_W'(i)) begin
          state_d[i] = RUN;
          id_d[i] = req_id;
          start_d[i] = 1'b1;
        end
        // a done coinciding with the start pulse belongs to a previous run and is dropped
        RUN: if (rca_done[i] && !start_q[i]) begin
          state_d[i] = DONE;
          res_d[i] = rca_result[i];
          err_d[i] = 1'b0;
        end
`ifdef RCA_SCHED_TIMEOUT_EN
        else if (cnt_q[i] == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d[i] = DONE;
          res_d[i] = '0;
          err_d[i] = 1'b1;
        end
`endif
        default: ;
      endcase
    if (pend_acc) begin
      cfg_pending_d = 1'b1;
      cfg_id_d = req_id;
      cfg_wr_d = sel_ok;
      cfg_sel_d = sel_ok ? req_rca_sel : '0;
    end
    if (wb_load) begin
      wb_done_d = 1'b1;
      wb_id_d = cfg_id_q;
      wb_rd_d = '0;
      wb_err_d = 1'b0;
      for (int i = 0; i < NUM_RCAS; i++)
        if (arb_gnt[i]) begin
          wb_id_d = id_q[i];
          wb_rd_d = res_q[i];
          wb_err_d = err_q[i];
          state_d[i] = IDLE;
        end
      if (arb_gnt[NUM_RCAS]) cfg_pending_d = 1'b0;
    end else if (wb_ack) begin
      wb_done_d = 1'b0;
      wb_id_d = '0;
      wb_rd_d = '0;
      wb_err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_RCAS; i++) begin
        state_q[i] <= IDLE;
        id_q[i] <= '0;
        res_q[i] <= '0;
      end
      err_q <= '0;
      start_q <= '0;
      cfg_wr_q <= 1'b0;
      cfg_sel_q <= '0;
      cfg_pending_q <= 1'b0;
      cfg_id_q <= '0;
      wb_done_q <= 1'b0;
      wb_id_q <= '0;
      wb_rd_q <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      res_q <= res_d;
      err_q <= err_d;
      start_q <= start_d;
      cfg_wr_q <= cfg_wr_d;
      cfg_sel_q <= cfg_sel_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_id_q <= cfg_id_d;
      wb_done_q <= wb_done_d;
      wb_id_q <= wb_id_d;
      wb_rd_q <= wb_rd_d;
      wb_err_q <= wb_err_d;
    end
  assign rca_start = start_q;
  assign cfg_wr_en = cfg_wr_q;
  assign cfg_rca_sel = cfg_sel_q;
  assign wb_done = wb_done_q;
  assign wb_id = wb_id_q;
  assign wb_rd = wb_rd_q;
  assign wb_err = wb_err_q;
endmodule

// File: tb/tb_rca_dispatch_scheduler.sv
// tb_rca_dispatch_scheduler: scoreboard bench for rca_dispatch_scheduler with directed vectors
module tb_rca_dispatch_scheduler;
  localparam int NR = 3, IDW = 3, XL = 32, NWP = 5, SW = 2;
  typedef logic [NWP-1:0][XL-1:0] rd_t;
  typedef struct {
    logic [IDW-1:0] id;
    rd_t rd;
    logic err;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_is_config = 0;
  logic [IDW-1:0] req_id = '0;
  logic [SW-1:0] req_rca_sel = '0;
  logic cfg_wr_en;
  logic [SW-1:0] cfg_rca_sel;
  logic [NR-1:0] rca_start, rca_busy;
  logic [NR-1:0] rca_done = '0;
  logic [NR-1:0][NWP-1:0][XL-1:0] rca_result = '0;
  logic wb_done, wb_err;
  logic wb_ack = 1;
  logic [IDW-1:0] wb_id;
  rd_t wb_rd;
  exp_t sb[$];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  rca_dispatch_scheduler #(.NUM_RCAS(NR), .ID_W(IDW), .XLEN(XL), .NUM_WRITE_PORTS(NWP), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_rca_sel(req_rca_sel), .req_is_config(req_is_config), .cfg_wr_en(cfg_wr_en),
    .cfg_rca_sel(cfg_rca_sel), .rca_start(rca_start), .rca_done(rca_done), .rca_result(rca_result),
    .rca_busy(rca_busy), .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd), .wb_err(wb_err), .wb_ack(wb_ack)
  );
  task automatic check(input string name, input logic [NWP*XL-1:0] got, input logic [NWP*XL-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_wb(input logic [IDW-1:0] id, input rd_t rd, input logic err);
    exp_t e;
    e.id = id;
    e.rd = rd;
    e.err = err;
    sb.push_back(e);
  endtask
  task automatic issue(input logic [SW-1:0] sel, input logic [IDW-1:0] id, input logic cfg);
    int n;
    n = 0;
    req_valid = 1;
    req_rca_sel = sel;
    req_id = id;
    req_is_config = cfg;
    #1;
    while (!req_ready && n < 50) begin
      tick();
      #1;
      n++;
    end
    check("req_accept", req_ready, 1);
    tick();
    req_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask
  function automatic rd_t mk_rd(input int base);
    rd_t r;
    for (int k = 0; k < NWP; k++) r[k] = XL'(base + k);
    return r;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && wb_done && wb_ack) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_wb: got id %0d expected none", wb_id);
      end else begin
        e = sb.pop_front();
        check("wb_id", wb_id, e.id);
        check("wb_rd", wb_rd, e.rd);
        check("wb_err", wb_err, e.err);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    #2;
    check("rst_wb_done", wb_done, 0);
    check("rst_busy", rca_busy, 0);
    check("rst_start", rca_start, 0);
    check("rst_cfg_wr", cfg_wr_en, 0);
    check("rst_wb_id", wb_id, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_err", wb_err, 0);
    tick();
    tick();
    rst_n = 1;
    tick();
    // exec to RCA 1, done at cycle 5, writeback at cycle 7
    issue(1, 2, 0);
    check("t1_start", rca_start, 3'b010);
    check("t1_busy", rca_busy[1], 1);
    tick();
    check("t1_start_pulse", rca_start, 0);
    repeat (3) tick();
    rca_done = 3'b010;
    rca_result[1] = mk_rd(1);
    expect_wb(2, mk_rd(1), 0);
    tick();
    rca_done = 0;
    check("t1_busy_done", rca_busy[1], 1);
    check("t1_wb_early", wb_done, 0);
    tick();
    check("t1_wb_done", wb_done, 1);
    check("t1_busy_clear", rca_busy[1], 0);
    tick();
    check("t1_wb_clear", wb_done, 0);
    // config blocked while target RCA runs
    issue(0, 1, 0);
    req_valid = 1;
    req_rca_sel = 0;
    req_id = 4;
    req_is_config = 1;
    #1;
    check("t2_cfg_blocked", req_ready, 0);
    tick();
    tick();
    check("t2_cfg_blocked_run", req_ready, 0);
    rca_done = 3'b001;
    rca_result[0] = mk_rd(10);
    expect_wb(1, mk_rd(10), 0);
    tick();
    rca_done = 0;
    check("t2_cfg_blocked_done", req_ready, 0);
    tick();
    check("t2_cfg_ready", req_ready, 1);
    check("t2_cfg_wr_early", cfg_wr_en, 0);
    expect_wb(4, '0, 0);
    tick();
    req_valid = 0;
    req_is_config = 0;
    check("t2_cfg_wr", cfg_wr_en, 1);
    check("t2_cfg_sel", cfg_rca_sel, 0);
    tick();
    check("t2_cfg_wr_pulse", cfg_wr_en, 0);
    drain();
    // simultaneous completions with wb_ack low
    issue(0, 5, 0);
    issue(1, 6, 0);
    issue(2, 7, 0);
    tick();
    wb_ack = 0;
    rca_done = 3'b111;
    for (int i = 0; i < NR; i++) rca_result[i] = mk_rd(100 * i);
    expect_wb(5, mk_rd(0), 0);
    expect_wb(6, mk_rd(100), 0);
    expect_wb(7, mk_rd(200), 0);
    tick();
    rca_done = 0;
    tick();
    check("t3_wb_first", wb_done, 1);
    repeat (3) begin
      tick();
      check("t3_hold_id", wb_id, 5);
      check("t3_hold_rd", wb_rd, mk_rd(0));
    end
    wb_ack = 1;
    drain();
    // pointer now at the config index: config wins before slot 0
    issue(0, 1, 0);
    tick();
    rca_done = 3'b001;
    rca_result[0] = mk_rd(40);
    req_valid = 1;
    req_rca_sel = 1;
    req_id = 3;
    req_is_config = 1;
    #1;
    check("t3b_cfg_ready", req_ready, 1);
    expect_wb(3, '0, 0);
    expect_wb(1, mk_rd(40), 0);
    tick();
    rca_done = 0;
    req_valid = 0;
    req_is_config = 0;
    check("t3b_cfg_wr", cfg_wr_en, 1);
    check("t3b_cfg_sel", cfg_rca_sel, 1);
    drain();
    // out-of-range select takes the pending path
    expect_wb(6, '0, 0);
    issue(3, 6, 0);
    check("t4_no_cfg_wr", cfg_wr_en, 0);
    check("t4_no_start", rca_start, 0);
    drain();
    // reset mid-operation
    issue(1, 1, 0);
    issue(2, 2, 0);
    tick();
    wb_ack = 0;
    rca_done = 3'b100;
    tick();
    rca_done = 0;
    tick();
    tick();
    check("t5_pending_wb", wb_done, 1);
    rst_n = 0;
    #1;
    check("t5_rst_wb_done", wb_done, 0);
    check("t5_rst_wb_id", wb_id, 0);
    check("t5_rst_wb_rd", wb_rd, 0);
    check("t5_rst_busy", rca_busy, 0);
    check("t5_rst_start", rca_start, 0);
    tick();
    rst_n = 1;
    wb_ack = 1;
    tick();
    rca_done = 3'b010;
    tick();
    rca_done = 0;
    check("t5_late_done_busy", rca_busy, 0);
    repeat (3) begin
      tick();
      check("t5_late_done_wb", wb_done, 0);
    end
`ifdef RCA_SCHED_TIMEOUT_EN
    expect_wb(3, '0, 1);
    issue(0, 3, 0);
    drain();
`endif
    repeat (3) tick();
    check("final_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rca_dispatch_scheduler.md
# rca_dispatch_scheduler

Sequences the reconfigurable compute accelerators (RCAs) behind the RCA issue port. The block accepts execution and configuration requests from issue and gates configuration writes so grid/IO/result muxes never change under a running grid. It starts the selected RCA and tracks per-RCA busy state. It also arbitrates completed results round-robin onto the single multi-register RCA writeback port.

## Interface
Parameters:
- NUM_RCAS, 3, number of RCA grid instances
- ID_W, 3, instruction id width
- XLEN, 32, data width
- NUM_WRITE_PORTS, 5, destination registers per writeback
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with RCA_SCHED_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req_valid  in  1  request from issue
- req_ready  out  1  request accepted when req_valid && req_ready
- req_id  in  ID_W  instruction id
- req_rca_sel  in  $clog2(NUM_RCAS+1)  target RCA
- req_is_config  in  1  configuration instruction
- cfg_wr_en  out  1  one-cycle config-register write strobe
- cfg_rca_sel  out  $clog2(NUM_RCAS+1)  RCA being configured
- rca_start  out  NUM_RCAS  one-hot start pulse
- rca_done  in  NUM_RCAS  per-RCA completion pulse
- rca_result  in  NUM_RCAS x NUM_WRITE_PORTS x XLEN  per-RCA results, valid with rca_done
- rca_busy  out  NUM_RCAS  slot not IDLE
- wb_done  out  1  writeback valid
- wb_id  out  ID_W  id of writeback
- wb_rd  out  NUM_WRITE_PORTS x XLEN  writeback data
- wb_err  out  1  watchdog-forced completion
- wb_ack  in  1  writeback consumed

## Operation
Each RCA has a slot FSM with states IDLE, RUN and DONE.

Slot transitions:
- IDLE -> RUN on an accepted exec request with a matching req_rca_sel. The slot latches req_id. rca_start[i] pulses for one cycle in the next cycle.
- RUN -> DONE on rca_done[i]. The slot latches rca_result[i]. rca_done[i] in the same cycle as rca_start[i] is ignored.
- DONE -> IDLE when the slot wins arbitration and its contents are loaded into the writeback register.
- rca_done[i] outside RUN is ignored.

Request acceptance:
- Exec: req_ready = slot IDLE.
- Config: req_ready = slot IDLE && !cfg_pending.
- An accepted config asserts cfg_wr_en and cfg_rca_sel the next cycle, for one cycle. It sets cfg_pending with the latched id.
- req_rca_sel >= NUM_RCAS: accepted when !cfg_pending and routed to the cfg_pending path. The request produces no cfg_wr_en and no rca_start.

Writeback:
- Requesters are the DONE slots 0..NUM_RCAS-1 plus cfg_pending as index NUM_RCAS.
- Arbitration is round-robin. The pointer moves to winner+1 (mod NUM_RCAS+1).
- A load occurs when the output register is empty or wb_ack is high that cycle.
- The config winner drives wb_rd all zeros.
- wb_done, wb_id, wb_rd and wb_err are held stable until wb_ack.

## Timing
- Reset, asynchronous: all slots IDLE, cfg_pending=0, round-robin pointer=0. cfg_wr_en, rca_start, wb_done, wb_err, wb_id and wb_rd are all 0; rca_busy=0.
- Exec: accepted in cycle 0; rca_start in cycle 1. rca_done in cycle N (N>=2) gives DONE in N+1 and wb_done in N+2 when the output register is free.
- Config: accepted in cycle 0; cfg_wr_en in cycle 1; wb_done earliest in cycle 2.
- Throughput: with wb_ack held high, one writeback per cycle.
- A slot freed by a load at edge E can accept a new request in the cycle after E.
- Reset mid-operation aborts all slots. In-flight results are discarded, and the RCAs share rst_n.

## Configuration
- RCA_SCHED_TIMEOUT_EN defined: each slot has a counter cleared on entering RUN.
- If the counter reaches TIMEOUT_CYCLES while in RUN, the slot goes to DONE with zero results and an error flag. wb_err=1 accompanies that writeback.
- RCA_SCHED_TIMEOUT_EN undefined: no counters; wb_err is tied to 0 and a hung RCA holds its slot indefinitely.

## Structure
- Shared package (taiga_types): rca_slot_state_t enum (IDLE/RUN/DONE), NUM_RCAS, and a writeback struct {done, id, rd[NUM_WRITE_PORTS], err}.
- Sub-module: rca_rr_arbiter, parameterised on requester count, with one-hot grant and a pointer update on load.

## Test plan
- Exec to RCA 1 with id=2; rca_done[1] at cycle 5 with results 1..5 -> rca_start[1] at cycle 1; wb_done at cycle 7 with wb_id=2 and wb_rd=1..5; rca_busy[1] clears at cycle 7.
- Config to RCA 0 while RCA 0 is RUN -> req_ready=0 until RCA 0 writes back. Then cfg_wr_en pulses once, cfg_rca_sel=0, followed by a writeback with wb_rd all 0.
- rca_done on all 3 RCAs in the same cycle, wb_ack low for 4 cycles and then high -> writebacks in order 0,1,2. The next simultaneous set is granted starting at index 3 (config) and then 0.
- req_rca_sel=3 -> accepted, no rca_start, no cfg_wr_en, and a zero writeback with the request id.
- rst_n low mid-RUN with a pending writeback -> all outputs 0 immediately. A late rca_done after release is ignored.
- With RCA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, no rca_done -> writeback with wb_err=1 and zero data once the counter reaches 16.
